// File: rtl/hci_core_r_credit_buffer.sv
// rtl/hci_core_r_credit_buffer.sv - credit-gated response FIFO with r_ready backpressure
// Reads are admitted only while in-flight plus buffered responses stay within DEPTH.
module hci_core_r_credit_buffer #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int UW    = 1,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic            in_req_i,
  output logic            in_gnt_o,
  input  logic            in_wen_i,
  input  logic [AW-1:0]   in_add_i,
  input  logic [DW-1:0]   in_data_i,
  input  logic [DW/8-1:0] in_be_i,
  input  logic [UW-1:0]   in_user_i,
  output logic            in_r_valid_o,
  input  logic            in_r_ready_i,
  output logic [DW-1:0]   in_r_data_o,
  output logic [UW-1:0]   in_r_user_o,
  output logic            in_r_opc_o,
  output logic            out_req_o,
  input  logic            out_gnt_i,
  output logic            out_wen_o,
  output logic [AW-1:0]   out_add_o,
  output logic [DW-1:0]   out_data_o,
  output logic [DW/8-1:0] out_be_o,
  output logic [UW-1:0]   out_user_o,
  input  logic            out_r_valid_i,
  input  logic [DW-1:0]   out_r_data_i,
  input  logic [UW-1:0]   out_r_user_i,
  input  logic            out_r_opc_i,
  output logic [$clog2(DEPTH):0] credits_o,
  output logic            err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = DW + UW + 1;
  localparam logic [PW:0] PTR_ONE = 1;
  localparam logic [PW:0] CNT_ONE = 1;
  localparam logic [PW:0] CNT_MAX = DEPTH[PW:0];

  logic [EW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr, rd_ptr, cnt;
  logic          err;
  logic          empty, full, gated_req, inc, pop, push, push_ok;
  logic [EW-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // Writes bypass the credit check; only reads consume a response slot.
  assign gated_req = in_req_i & (~in_wen_i | (cnt < CNT_MAX));
  assign out_req_o = enable_i ? gated_req : in_req_i;
  assign in_gnt_o  = enable_i ? (out_gnt_i & gated_req) : out_gnt_i;

  assign out_wen_o  = in_wen_i;
  assign out_add_o  = in_add_i;
  assign out_data_o = in_data_i;
  assign out_be_o   = in_be_i;
  assign out_user_o = in_user_i;

  assign head         = mem[rd_ptr[PW-1:0]];
  assign in_r_valid_o = enable_i ? ~empty : out_r_valid_i;
  assign in_r_data_o  = enable_i ? head[EW-1 -: DW] : out_r_data_i;
  assign in_r_user_o  = enable_i ? head[UW:1] : out_r_user_i;
  assign in_r_opc_o   = enable_i ? head[0] : out_r_opc_i;

  assign inc     = enable_i & out_req_o & out_gnt_i & in_wen_i;
  assign pop     = enable_i & ~empty & in_r_ready_i;
  assign push    = enable_i & out_r_valid_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign push_ok = push & (~full | pop);

  assign credits_o = cnt;
  assign err_o     = err;

  always_ff @(posedge clk_i) begin
    if (!clear_i && push_ok)
      mem[wr_ptr[PW-1:0]] <= {out_r_data_i, out_r_user_i, out_r_opc_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !push_ok) err <= 1'b1;
      if (inc && !pop) begin
        cnt <= cnt + CNT_ONE;
      end else if (pop && !inc) begin
        if (cnt == '0) err <= 1'b1;
        else           cnt <= cnt - CNT_ONE;
      end
    end
  end

endmodule
